// File: rtl/karatsuba_seq_ctrl.sv
// Sequential Karatsuba multiplier: three half-width sub-products share one
// combinational radix-4 Booth multiplier over three consecutive cycles.

module radix4acc #(
  parameter int N = 10
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] prod
);

  logic signed [2*N-1:0] ae;
  logic signed [2*N-1:0] pp;
  logic signed [2*N-1:0] acc;
  logic        [N:0]     bext;
  logic        [2:0]     trip;

  assign ae   = (2*N)'(a);
  assign bext = {b, 1'b0};

  // NOTE: blocking assignments are correct here; acc is a combinational
  // running sum rebuilt from zero on every evaluation, not stored state.
  always_comb begin
    acc  = '0;
    pp   = '0;
    trip = '0;
    for (int i = 0; i < N / 2; i++) begin
      trip = bext[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: pp = ae;
        3'b011:         pp = ae <<< 1;
        3'b100:         pp = -(ae <<< 1);
        3'b101, 3'b110: pp = -ae;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
  end

  assign prod = acc;

endmodule

module karatsuba_seq_ctrl #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] p,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int H = W / 2;
  localparam int M = H + 2;

  typedef enum logic [2:0] {IDLE, LO, HI, MID, OUT} state_t;

  state_t state, next_state;

  logic        [W-1:0]   xr, yr;
  logic signed [M-1:0]   xl_e, yl_e, xh_e, yh_e, xs, ys;
  logic signed [M-1:0]   mul_a, mul_b;
  logic signed [2*M-1:0] prod, z0, z2, z1;
  logic signed [2*W-1:0] z0_e, z1_e, z2_e, p_next;

  assign xl_e = {{(M-H){1'b0}}, xr[H-1:0]};
  assign yl_e = {{(M-H){1'b0}}, yr[H-1:0]};
  assign xh_e = {{(M-H){xr[W-1]}}, xr[W-1:H]};
  assign yh_e = {{(M-H){yr[W-1]}}, yr[W-1:H]};
  assign xs   = xh_e + xl_e;
  assign ys   = yh_e + yl_e;

  radix4acc #(.N(M)) u_mul (
    .a    (mul_a),
    .b    (mul_b),
    .prod (prod)
  );

  // The combine runs modulo 2^(2W): truncating after a wider add is identical.
  assign z1     = prod - z2 - z0;
  assign z0_e   = (2*W)'(z0);
  assign z1_e   = (2*W)'(z1);
  assign z2_e   = (2*W)'(z2);
  assign p_next = (z2_e <<< (2 * H)) + (z1_e <<< H) + z0_e;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    mul_a      = '0;
    mul_b      = '0;
    unique case (state)
      IDLE: if (in_valid) next_state = LO;
      LO: begin
        mul_a      = xl_e;
        mul_b      = yl_e;
        next_state = HI;
      end
      HI: begin
        mul_a      = xh_e;
        mul_b      = yh_e;
        next_state = MID;
      end
      MID: begin
        mul_a      = xs;
        mul_b      = ys;
        next_state = OUT;
      end
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so a reset mid-operation leaves
  // p at zero and no stale partial product survives into the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr <= '0;
      yr <= '0;
      z0 <= '0;
      z2 <= '0;
      p  <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        xr <= x;
        yr <= y;
      end
      if (state == LO)  z0 <= prod;
      if (state == HI)  z2 <= prod;
      if (state == MID) p  <= p_next;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Self-checking bench for karatsuba_seq_ctrl: directed corners, backpressure,
// reset abort, back-to-back spacing and a randomized regression vs x*y.

module tb_karatsuba_seq_ctrl;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   x, y;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] p;
  logic           out_valid;
  logic           out_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  karatsuba_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Drives one request, waits for the result, optionally stalls the consumer,
  // then completes the output handshake. Returns observations only.
  task automatic do_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input int stall, input bit scramble,
                       output logic [2*W-1:0] pv, output int lat,
                       output bit stable_ok, output bit to);
    int n;
    to = 1'b0; stable_ok = 1'b1; lat = 0; pv = '0;
    x = xv; y = yv; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      to = 1'b1; in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (scramble) begin x = W'($urandom); y = W'($urandom); end
      @(posedge clk); #1; lat++;
    end
    if (lat >= 20) begin
      to = 1'b1;
      return;
    end
    pv = p;
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin x = W'($urandom); y = W'($urandom); end
      @(posedge clk); #1;
      if (p !== pv || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b p=%h expected 1 0 0", in_ready, out_valid, p);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0]   tx [5] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000};
    logic [W-1:0]   ty [5] = '{16'h5678, 16'hFFFF, 16'h8000, 16'h8000, 16'hABCD};
    logic [2*W-1:0] tp [5] = '{32'h06260060, 32'h00000001, 32'h40000000, 32'hC0008000, 32'h00000000};
    logic [2*W-1:0] pv;
    int lat;
    bit st, to;
    for (int k = 0; k < 5; k++) begin
      do_op(tx[k], ty[k], 0, 1'b0, pv, lat, st, to);
      checks++;
      if (to || pv !== tp[k] || lat !== 3) begin
        errors++;
        $display("FAIL directed_%0d x=%h y=%h p=%h lat=%0d timeout=%b expected p=%h lat=3",
                 k, tx[k], ty[k], pv, lat, to, tp[k]);
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_return_%0d in_ready=%b out_valid=%b expected 1 0", k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0]   x1, y1, x2, y2;
    logic [2*W-1:0] pv;
    int lat;
    bit ok;
    x1 = W'($urandom); y1 = W'($urandom);
    x2 = W'($urandom); y2 = W'($urandom);
    x = x1; y = y1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    x = x2; y = y2;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 3 || p !== ref_mul(x1, y1)) begin
      errors++;
      $display("FAIL bp_first p=%h lat=%0d expected p=%h lat=3", p, lat, ref_mul(x1, y1));
    end
    pv = p; ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (p !== pv || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_stall_stable p=%h out_valid=%b in_ready=%b expected p=%h 1 0", p, out_valid, in_ready, pv);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== 3 || p !== ref_mul(x2, y2)) begin
      errors++;
      $display("FAIL bp_second p=%h lat=%0d expected p=%h lat=3", p, lat, ref_mul(x2, y2));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_operand_change;
    logic [W-1:0]   xv, yv;
    logic [2*W-1:0] pv;
    int lat;
    bit st, to;
    for (int k = 0; k < 4; k++) begin
      xv = W'($urandom); yv = W'($urandom);
      do_op(xv, yv, 2, 1'b1, pv, lat, st, to);
      checks++;
      if (to || !st || pv !== ref_mul(xv, yv) || lat !== 3) begin
        errors++;
        $display("FAIL operand_change_%0d p=%h lat=%0d stable=%b timeout=%b expected p=%h lat=3",
                 k, pv, lat, st, to, ref_mul(xv, yv));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2*W-1:0] pv;
    int lat;
    bit st, to, seen;
    x = 16'h7123; y = 16'h9ABC; in_valid = 1'b1; out_ready = 1'b1;
    while (in_ready !== 1'b1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || p !== '0) begin
      errors++;
      $display("FAIL reset_mid_state in_ready=%b out_valid=%b p=%h expected 1 0 0", in_ready, out_valid, p);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_spurious out_valid pulse seen=%b expected 0", seen);
    end
    out_ready = 1'b0;
    do_op(16'd3, -16'sd5, 0, 1'b0, pv, lat, st, to);
    checks++;
    if (to || pv !== 32'hFFFFFFF1 || lat !== 3) begin
      errors++;
      $display("FAIL reset_mid_after p=%h lat=%0d timeout=%b expected p=fffffff1 lat=3", pv, lat, to);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] xs [4];
    logic [W-1:0] ys [4];
    int prev, a, n;
    for (int k = 0; k < 4; k++) begin xs[k] = W'($urandom); ys[k] = W'($urandom); end
    out_ready = 1'b1; in_valid = 1'b1; x = xs[0]; y = ys[0];
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      a = cyc;
      if (k > 0) begin
        checks++;
        if (a - prev !== 5) begin
          errors++;
          $display("FAIL b2b_spacing_%0d got %0d expected 5", k, a - prev);
        end
      end
      prev = a;
      @(posedge clk); #1;
      if (k < 3) begin x = xs[k+1]; y = ys[k+1]; end
      else in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== 3 || p !== ref_mul(xs[k], ys[k])) begin
        errors++;
        $display("FAIL b2b_result_%0d p=%h lat=%0d expected p=%h lat=3", k, p, n, ref_mul(xs[k], ys[k]));
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [W-1:0]   xv, yv;
    logic [2*W-1:0] pv;
    int lat, bad;
    bit st, to;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0:       begin xv = W'($urandom); yv = 16'h8000; end
        1:       begin xv = 16'h7FFF; yv = W'($urandom); end
        default: begin xv = W'($urandom); yv = W'($urandom); end
      endcase
      do_op(xv, yv, $urandom_range(0, 3), 1'b1, pv, lat, st, to);
      checks++;
      if (to || !st || pv !== ref_mul(xv, yv) || lat !== 3) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d x=%h y=%h p=%h lat=%0d stable=%b timeout=%b expected p=%h lat=3",
                   k, xv, yv, pv, lat, st, to, ref_mul(xv, yv));
        bad++;
      end
      if (to) break;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
